// File: rtl/argmax_sequencer_if.sv
// Score stream in, winning-class result out, plus frame control for argmax_sequencer.
interface argmax_sequencer_if #(
  parameter int unsigned BIT = 16
);
  logic           start;
  logic           in_valid;
  logic [BIT-1:0] in_data;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [3:0]     class_idx;
  logic [BIT-1:0] max_val;
  logic           sat_flag;
  logic           busy;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, class_idx, max_val, sat_flag, busy
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, class_idx, max_val, sat_flag, busy
  );
endinterface

// File: rtl/argmax_sequencer.sv
// Streaming argmax over N sign-magnitude scores per frame using one comparator;
// the winner is held for the consumer until acknowledged.
module argmax_sequencer #(
  parameter int unsigned BIT = 16,
  parameter int unsigned N   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  argmax_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_e;

  localparam logic [3:0]     LAST = 4'(N - 1);
  localparam logic [BIT-1:0] SAT  = {1'b1, {(BIT-1){1'b0}}};

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     run_idx_q, run_idx_d;
  logic [BIT-1:0] run_val_q, run_val_d;
  logic [3:0]     class_idx_q, class_idx_d;
  logic [BIT-1:0] max_val_q, max_val_d;
  logic           sat_q, sat_d;
  logic           beats;
  logic [3:0]     win_idx;
  logic [BIT-1:0] win_val;

  // Strict "a ranks above b": SAT first, then positives by magnitude, then
  // negatives by smallest magnitude. Equal values never rank above each other.
  function automatic logic ranks_above(input logic [BIT-1:0] a, input logic [BIT-1:0] b);
    if (a == SAT)                 return (b != SAT);
    else if (b == SAT)            return 1'b0;
    else if (a[BIT-1] != b[BIT-1]) return b[BIT-1];
    else if (a[BIT-1])            return (a[BIT-2:0] < b[BIT-2:0]);
    else                          return (a[BIT-2:0] > b[BIT-2:0]);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      run_idx_q   <= '0;
      run_val_q   <= '0;
      class_idx_q <= '0;
      max_val_q   <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_idx_q   <= run_idx_d;
      run_val_q   <= run_val_d;
      class_idx_q <= class_idx_d;
      max_val_q   <= max_val_d;
      sat_q       <= sat_d;
    end
  end

  always_comb begin
    beats   = (cnt_q == '0) || ranks_above(bus.in_data, run_val_q);
    win_idx = beats ? cnt_q : run_idx_q;
    win_val = beats ? bus.in_data : run_val_q;

    state_d     = state_q;
    cnt_d       = cnt_q;
    run_idx_d   = run_idx_q;
    run_val_d   = run_val_q;
    class_idx_d = class_idx_q;
    max_val_d   = max_val_q;
    sat_d       = sat_q;

    // start outranks any accept or result handshake in the same cycle
    if (bus.start) begin
      state_d   = COLLECT;
      cnt_d     = '0;
      run_idx_d = '0;
      run_val_d = '0;
    end else begin
      case (state_q)
        IDLE: ;
        COLLECT: begin
          if (bus.in_valid) begin
            run_idx_d = win_idx;
            run_val_d = win_val;
            cnt_d     = cnt_q + 4'd1;
            if (cnt_q == LAST) begin
              state_d     = HOLD;
              cnt_d       = '0;
              class_idx_d = win_idx;
              max_val_d   = win_val;
              sat_d       = (win_val == SAT);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.busy      = (state_q == COLLECT);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.class_idx = class_idx_q;
  assign bus.max_val   = max_val_q;
  assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_argmax_sequencer.sv
// Randomized and directed checks of argmax_sequencer against a value-ranking argmax model.
module tb_argmax_sequencer;
  localparam int unsigned BIT = 8;
  localparam int unsigned N   = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  argmax_sequencer_if #(.BIT(BIT)) bus();

  argmax_sequencer #(.BIT(BIT), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Signed numeric rank of a score; negative zero (saturation) outranks everything.
  function automatic int rank(input logic [7:0] v);
    if (v == 8'h80) return 1000;
    return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
  endfunction

  function automatic void ref_argmax(input logic [7:0] s[$], output logic [3:0] idx,
                                     output logic [7:0] val);
    idx = 4'd0;
    val = s[0];
    for (int i = 1; i < s.size(); i++)
      if (rank(s[i]) > rank(val)) begin
        idx = 4'(i);
        val = s[i];
      end
  endfunction

  function automatic logic [7:0] rand_score();
    int unsigned r;
    logic        sg;
    logic [6:0]  mg;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'h80;
    if (r < 4)  return 8'($urandom);
    sg = 1'($urandom_range(0, 1));
    mg = 7'($urandom_range(0, 5));
    return {sg, mg};
  endfunction

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("start_in_ready", 32'(bus.in_ready), 1);
    check("start_busy", 32'(bus.busy), 1);
  endtask

  task automatic feed(input logic [7:0] s[$], input int n_acc, input bit gaps);
    int  k = 0;
    int  guard = 0;
    logic acc;
    while (k < n_acc && guard < 2000) begin
      bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.in_data  = bus.in_valid ? s[k] : 8'h80;
      #3;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    if (guard >= 2000) check("feed_timeout", 32'(k), 32'(n_acc));
  endtask

  task automatic expect_result(input string tag, input logic [3:0] ei, input logic [7:0] ev,
                               input logic es);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 1);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    check({tag, "_class_idx"}, 32'(bus.class_idx), 32'(ei));
    check({tag, "_max_val"}, 32'(bus.max_val), 32'(ev));
    check({tag, "_sat_flag"}, 32'(bus.sat_flag), 32'(es));
  endtask

  task automatic consume(input int wait_cyc, input logic [3:0] ei, input logic [7:0] ev,
                         input logic es);
    for (int c = 0; c < wait_cyc; c++) begin
      @(posedge clk); #1;
      expect_result("holdoff", ei, ev, es);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("idle_out_valid", 32'(bus.out_valid), 0);
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_in_ready", 32'(bus.in_ready), 0);
    check("idle_class_kept", 32'(bus.class_idx), 32'(ei));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_class_idx"}, 32'(bus.class_idx), 0);
    check({tag, "_max_val"}, 32'(bus.max_val), 0);
    check({tag, "_sat_flag"}, 32'(bus.sat_flag), 0);
  endtask

  task automatic random_frame(output logic [7:0] s[$]);
    s = {};
    for (int i = 0; i < int'(N); i++) s.push_back(rand_score());
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] s2[$];
    logic [3:0] ei;
    logic [7:0] ev;

    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    #1;
    check_reset_values("reset");
    #13 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_values("post_reset");

    // Ranking with stalls, tie at class 4 ignored; long consumer hold-off
    s = '{8'h03, 8'h85, 8'h0C, 8'h07, 8'h0C, 8'h00, 8'h81, 8'h09, 8'h02, 8'h01};
    pulse_start();
    feed(s, N, 1'b1);
    expect_result("ranking", 4'd2, 8'h0C, 1'b0);
    consume(20, 4'd2, 8'h0C, 1'b0);

    s = '{8'h89, 8'h83, 8'h87, 8'h83, 8'h94, 8'h8F, 8'h84, 8'hB2, 8'h88, 8'h86};
    pulse_start();
    feed(s, N, 1'b1);
    expect_result("all_neg", 4'd1, 8'h83, 1'b0);
    consume(2, 4'd1, 8'h83, 1'b0);

    s = '{8'h7F, 8'h05, 8'h22, 8'h7E, 8'h01, 8'h00, 8'h80, 8'h7F, 8'h80, 8'h10};
    pulse_start();
    feed(s, N, 1'b0);
    expect_result("sat", 4'd6, 8'h80, 1'b1);
    consume(1, 4'd6, 8'h80, 1'b1);

    // Restart after 5 accepts; in_valid with SAT in the start cycle must be ignored
    s = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    s2 = '{8'h11, 8'h22, 8'h05, 8'h33, 8'h33, 8'h81, 8'h00, 8'h20, 8'h32, 8'h01};
    pulse_start();
    feed(s, 5, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h80;
    pulse_start();
    bus.in_valid = 1'b0;
    feed(s2, N, 1'b1);
    expect_result("restart", 4'd3, 8'h33, 1'b0);
    consume(0, 4'd3, 8'h33, 1'b0);

    // Asynchronous reset in the middle of a frame
    pulse_start();
    feed(s, 3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_values("after_mid_reset");

    // start coincident with out_ready during HOLD
    random_frame(s);
    ref_argmax(s, ei, ev);
    pulse_start();
    feed(s, N, 1'b1);
    expect_result("pre_hold_start", ei, ev, ev == 8'h80);
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    check("hold_start_in_ready", 32'(bus.in_ready), 1);
    check("hold_start_out_valid", 32'(bus.out_valid), 0);
    check("hold_start_class_kept", 32'(bus.class_idx), 32'(ei));
    random_frame(s);
    ref_argmax(s, ei, ev);
    feed(s, N, 1'b1);
    expect_result("after_hold_start", ei, ev, ev == 8'h80);
    consume(1, ei, ev, ev == 8'h80);

    for (int f = 0; f < 20; f++) begin
      random_frame(s);
      ref_argmax(s, ei, ev);
      pulse_start();
      feed(s, N, 1'b1);
      expect_result("random", ei, ev, ev == 8'h80);
      consume(int'($urandom_range(0, 3)), ei, ev, ev == 8'h80);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/argmax_sequencer.md
# argmax_sequencer

Streaming argmax controller for the classifier output layer. Accepts the N class scores (sign-magnitude, `bit` wide) one per handshake as the final layer produces them, and tracks the running maximum and its class index. After the last score it presents the winning class to the display/result logic and holds it until that logic acknowledges it. This replaces a wide combinational 10-way compare with one comparator and a frame counter.

## Interface
- `bit`, 16, score width; sign-magnitude (MSB = sign, `bit-1` LSBs = magnitude).
- `N`, 10, scores per frame; 2..16.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse; begins a new frame, in any state.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  `bit`  class score; the k-th accepted word is class k.
- `in_ready`  out  1  block accepts a score this cycle.
- `out_valid`  out  1  result valid, held until accepted.
- `out_ready`  in  1  consumer accepts the result.
- `class_idx`  out  4  winning class index, 0..N-1.
- `max_val`  out  `bit`  winning score.
- `sat_flag`  out  1  winning score is the saturation code.
- `busy`  out  1  frame in progress (COLLECT).

## Operation
- Saturation code SAT = {1'b1, {(bit-1){1'b0}}} (negative zero). It is produced by the upstream layer on overflow.
- Total ranking, highest first:
  - SAT.
  - Positive values, by larger magnitude.
  - Negative values, by smaller magnitude.
- Replacement rule: the first word of a frame always loads. Each later word replaces the running max only if it ranks strictly higher. On ties the earliest class wins, so a second SAT never displaces the first.
- States:
  - IDLE: `in_ready`=0, `out_valid`=0. On `start`, go to COLLECT.
  - COLLECT: `in_ready`=1, `busy`=1. An accept is `in_valid && in_ready`. Each accept compares against the running max and increments `cnt` (4 bits). The accept with `cnt`==N-1 loads the final result and goes to HOLD. `in_valid` low stalls with no state change.
  - HOLD: `out_valid`=1 and `in_ready`=0; outputs stable. `out_valid && out_ready` returns to IDLE.
- `start` in any state (including HOLD with `out_valid` high):
  - clears `cnt` and the running max, drops `out_valid`, and enters COLLECT next cycle.
  - any `in_valid` in the same cycle is ignored.
  - an unaccepted result is discarded.
- `start` takes priority over a simultaneous final accept and over a simultaneous `out_ready`.
- `class_idx`, `max_val` and `sat_flag` are registered. They are updated only on entry to HOLD and keep their last values in IDLE and COLLECT.

## Timing
- Reset values:
  - state IDLE, `cnt`=0.
  - `in_ready`=0, `out_valid`=0, `busy`=0.
  - `class_idx`=0, `max_val`=0, `sat_flag`=0.
- `in_ready` rises the cycle after `start`. There is no combinational path from `in_valid` to `in_ready`.
- Latency: `out_valid` is high the cycle after the N-th accept. Minimum frame time is 1 (`start`) + N accepts + 1 cycles.
- `out_valid` stays high, with stable data, for as long as `out_ready` is low.
- Back-to-back frames:
  - `out_ready` with `out_valid` gives IDLE next cycle, and a new `start` is then accepted.
  - Alternatively, `start` can be asserted during HOLD.
- Reset mid-frame clears everything immediately, asynchronously. No partial result is ever presented.

## Test plan
- Ranking and stall handling. Setup: bit=8, N=10; start, then scores 3,-5,12,7,12,0,-1,9,2,1 with `in_valid` gaps. Required: after the 10th accept, `out_valid`=1 with `class_idx`=2 and `max_val`=0x0C (the tie at class 4 is ignored), `sat_flag`=0.
- All-negative frame. Stimulus: all scores negative, -9,-3,-7,-3,-20,… Required: `class_idx`=1, `max_val`=0x83.
- Saturation codes. Stimulus: SAT 0x80 at class 6 and again at class 8, with +127 at class 0. Required: `class_idx`=6, `sat_flag`=1.
- Consumer hold-off. Stimulus: hold `out_ready`=0 for 20 cycles, then pulse it. Required: outputs stable and `in_ready`=0 throughout; IDLE the cycle after the pulse.
- Restart mid-frame. Stimulus: `start` after 5 accepts, then a full new frame. Required: result reflects only the new frame; `cnt` restarts at 0.
- Reset and output-side restart. Stimulus: assert `rst_n` low mid-COLLECT. Required: all outputs return to reset values immediately. Stimulus: `start` during HOLD, coincident with `out_ready`. Required: COLLECT next cycle, `out_valid`=0.
